// File: rtl/mipi_rx_idelay_trainer_if.sv
// Control/status bundle between the idelay trainer and its environment.
// The trainer connects through the slave modport; whoever drives start and
// the aligner observations (RX wrapper glue or a bench) uses master.
interface mipi_rx_idelay_trainer_if #(
   parameter int DLY_W = 9
);
   logic             I_start;
   logic             I_hs_valid;
   logic [3:0]       I_lane_error;
   logic [DLY_W-1:0] O_clk_lane_idelay;
   logic [DLY_W-1:0] O_data_lane0_idelay;
   logic [DLY_W-1:0] O_data_lane1_idelay;
   logic [DLY_W-1:0] O_data_lane2_idelay;
   logic [DLY_W-1:0] O_data_lane3_idelay;
   logic             O_busy;
   logic             O_done;
   logic [3:0]       O_lane_fail;

   modport slave (
      input  I_start, I_hs_valid, I_lane_error,
      output O_clk_lane_idelay, O_data_lane0_idelay, O_data_lane1_idelay,
             O_data_lane2_idelay, O_data_lane3_idelay, O_busy, O_done, O_lane_fail
   );

   modport master (
      output I_start, I_hs_valid, I_lane_error,
      input  O_clk_lane_idelay, O_data_lane0_idelay, O_data_lane1_idelay,
             O_data_lane2_idelay, O_data_lane3_idelay, O_busy, O_done, O_lane_fail
   );
endinterface

// File: rtl/mipi_rx_idelay_trainer.sv
// Per-lane input-delay training for the 4-lane MIPI D-PHY RX path.
// Sweeps one common data tap, scores every sweep point per lane from the
// aligner error/valid flags, then places each lane at the centre of its
// widest passing window. Lanes without a usable window fall back to
// DEFAULT_DLY and are flagged in O_lane_fail.
module mipi_rx_idelay_trainer #(
   parameter int DLY_W       = 9,
   parameter int DLY_MAX     = 511,
   parameter int DLY_STEP    = 8,
   parameter int SETTLE_CYC  = 64,
   parameter int DWELL_CYC   = 4096,
   parameter int MIN_PASS    = 4,
   parameter int DEFAULT_DLY = 128,
   parameter int CLK_DLY     = 0
) (
   input  logic                             I_clk,
   input  logic                             I_rst_n,
   mipi_rx_idelay_trainer_if.slave          bus
);

   localparam int NPTS    = DLY_MAX / DLY_STEP + 1;
   localparam int LEN_W   = $clog2(NPTS + 1);
   localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SPAN_W  = DLY_W + LEN_W;

   typedef enum logic [2:0] {
      IDLE, SETTLE, DWELL, EVAL, APPLY, DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [CNT_W-1:0]   r_cnt;
   logic [DLY_W-1:0]   r_tap;
   logic [3:0]         r_err;
   logic               r_seen;
   logic               r_busy;
   logic               r_done;
   logic [3:0]         r_lane_fail;
   logic [DLY_W-1:0]   r_dly        [4];
   logic [LEN_W-1:0]   r_cur_len    [4];
   logic [DLY_W-1:0]   r_cur_start  [4];
   logic [LEN_W-1:0]   r_best_len   [4];
   logic [DLY_W-1:0]   r_best_start [4];

   logic               w_start_ok;
   logic               w_settle_end;
   logic               w_dwell_end;
   logic [DLY_W:0]     w_nt;
   logic               w_last_pt;
   logic [3:0]         w_pass;
   logic [3:0]         w_close;
   logic [3:0]         w_new_best;
   logic [3:0]         w_fail;
   logic [LEN_W-1:0]   w_run_len    [4];
   logic [DLY_W-1:0]   w_run_start  [4];
   logic [DLY_W-1:0]   w_centre     [4];

   assign w_start_ok   = ((r_state == IDLE) || (r_state == DONE)) && bus.I_start;
   assign w_settle_end = (r_cnt == CNT_W'(SETTLE_CYC - 1));
   assign w_dwell_end  = (r_cnt == CNT_W'(DWELL_CYC - 1));
   // One bit wider than the tap so the step past DLY_MAX cannot wrap to a low tap.
   assign w_nt         = {1'b0, r_tap} + (DLY_W + 1)'(DLY_STEP);
   assign w_last_pt    = (w_nt > (DLY_W + 1)'(DLY_MAX));

   // Per-lane scoring of the current point plus the centre pick used by APPLY.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      w_pass     = '0;
      w_close    = '0;
      w_new_best = '0;
      w_fail     = '0;
      for (int n = 0; n < 4; n++) begin
         w_pass[n]      = r_seen & ~r_err[n];
         w_run_len[n]   = w_pass[n] ? r_cur_len[n] + LEN_W'(1) : r_cur_len[n];
         w_run_start[n] = (w_pass[n] && (r_cur_len[n] == '0)) ? r_tap : r_cur_start[n];
         // The last point closes every run, including one just extended.
         w_close[n]     = ~w_pass[n] | w_last_pt;
         // Strict compare: the lowest of equally long windows is kept.
         w_new_best[n]  = w_close[n] && (w_run_len[n] > r_best_len[n]);
         w_fail[n]      = (r_best_len[n] < LEN_W'(MIN_PASS));
         w_centre[n]    = r_best_start[n] + DLY_W'(((SPAN_W'(r_best_len[n]) - SPAN_W'(1))
                                                     * SPAN_W'(DLY_STEP)) >> 1);
      end
   end

   // Next-state decode of the sweep sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, DONE: if (bus.I_start) w_state_nxt = SETTLE;
         SETTLE:     if (w_settle_end) w_state_nxt = DWELL;
         DWELL:      if (w_dwell_end) w_state_nxt = EVAL;
         EVAL:       w_state_nxt = w_last_pt ? APPLY : SETTLE;
         APPLY:      w_state_nxt = DONE;
         default:    w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) r_state <= IDLE;
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      else          r_state <= w_state_nxt;
   end

   // Sweep datapath: counters, sticky flags, run trackers, taps and status.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_cnt       <= '0;
         r_tap       <= '0;
         r_err       <= '0;
         r_seen      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_lane_fail <= '0;
         // NOTE: the per-lane arrays are small flop banks, not RAM, so they are reset like any register.
         for (int n = 0; n < 4; n++) begin
            r_dly[n]        <= DLY_W'(DEFAULT_DLY);
            r_cur_len[n]    <= '0;
            r_cur_start[n]  <= '0;
            r_best_len[n]   <= '0;
            r_best_start[n] <= '0;
         end
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_start_ok) begin
                  r_cnt       <= '0;
                  r_tap       <= '0;
                  r_err       <= '0;
                  r_seen      <= 1'b0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_lane_fail <= '0;
                  for (int n = 0; n < 4; n++) begin
                     r_dly[n]        <= '0;
                     r_cur_len[n]    <= '0;
                     r_cur_start[n]  <= '0;
                     r_best_len[n]   <= '0;
                     r_best_start[n] <= '0;
                  end
               end
            end
            SETTLE: begin
               r_cnt <= w_settle_end ? '0 : r_cnt + CNT_W'(1);
            end
            DWELL: begin
               r_cnt  <= w_dwell_end ? '0 : r_cnt + CNT_W'(1);
               r_err  <= r_err | bus.I_lane_error;
               r_seen <= r_seen | bus.I_hs_valid;
            end
            EVAL: begin
               for (int n = 0; n < 4; n++) begin
                  if (w_new_best[n]) begin
                     r_best_len[n]   <= w_run_len[n];
                     r_best_start[n] <= w_run_start[n];
                  end
                  r_cur_len[n]   <= w_close[n] ? '0 : w_run_len[n];
                  r_cur_start[n] <= w_run_start[n];
               end
               if (!w_last_pt) begin
                  r_tap  <= w_nt[DLY_W-1:0];
                  r_err  <= '0;
                  r_seen <= 1'b0;
                  for (int n = 0; n < 4; n++) r_dly[n] <= w_nt[DLY_W-1:0];
               end
            end
            APPLY: begin
               r_busy      <= 1'b0;
               r_done      <= 1'b1;
               r_lane_fail <= w_fail;
               for (int n = 0; n < 4; n++)
                  r_dly[n] <= w_fail[n] ? DLY_W'(DEFAULT_DLY) : w_centre[n];
            end
            default: ;
         endcase
      end
   end

   assign bus.O_clk_lane_idelay   = DLY_W'(CLK_DLY);
   assign bus.O_data_lane0_idelay = r_dly[0];
   assign bus.O_data_lane1_idelay = r_dly[1];
   assign bus.O_data_lane2_idelay = r_dly[2];
   assign bus.O_data_lane3_idelay = r_dly[3];
   assign bus.O_busy              = r_busy;
   assign bus.O_done              = r_done;
   assign bus.O_lane_fail         = r_lane_fail;

endmodule

// File: tb/tb_mipi_rx_idelay_trainer.sv
// Directed bench for the idelay trainer. Settle/dwell are shortened so a
// full 64-point sweep is a few hundred cycles; tap range and step keep their
// default values so the hand-computed centre taps apply unchanged.
module tb_mipi_rx_idelay_trainer;

   localparam int DLY_W = 9;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   mipi_rx_idelay_trainer_if #(.DLY_W(DLY_W)) bus ();

   mipi_rx_idelay_trainer #(
      .DLY_W      (DLY_W),
      .DLY_MAX    (511),
      .DLY_STEP   (8),
      .SETTLE_CYC (4),
      .DWELL_CYC  (8),
      .MIN_PASS   (4),
      .DEFAULT_DLY(128),
      .CLK_DLY    (0)
   ) dut (
      .I_clk  (clk),
      .I_rst_n(rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Channel model: does lane l see a clean eye at data tap t in this scenario.
   function automatic bit lane_pass(input int mode, input int l, input int t);
      bit p;
      p = 1'b0;
      case (mode)
         0: p = (l == 0) ? (t >= 64 && t <= 192) : (l == 1);
         1: case (l)
               0: p = (t <= 24) || (t >= 400 && t <= 424);
               1: p = (t <= 40) || (t >= 200 && t <= 320);
               2: p = (t >= 400);
               default: p = 1'b0;
            endcase
         2: case (l)
               0: p = (t <= 16);
               1: p = (t <= 24);
               default: p = 1'b1;
            endcase
         default: p = 1'b1;
      endcase
      return p;
   endfunction

   // Launch a sweep and play the channel until busy drops; counts tap steps
   // seen while busy and optionally pokes start mid-sweep.
   task automatic run_sweep(input int mode, input bit poke, output int points);
      logic [DLY_W-1:0] prev;
      logic [3:0]       e;
      bit               timed_out;
      int               t;
      prev           = bus.O_data_lane0_idelay;
      points         = 0;
      timed_out      = 1'b1;
      bus.I_hs_valid = (mode != 3);
      @(negedge clk);
      bus.I_start = 1'b1;
      @(negedge clk);
      bus.I_start = 1'b0;
      check($sformatf("m%0d_busy_on_start", mode), 32'(bus.O_busy), 32'd1);
      check($sformatf("m%0d_done_cleared", mode), 32'(bus.O_done), 32'd0);
      for (int cyc = 0; cyc < 5000; cyc++) begin
         if (!bus.O_busy) begin
            timed_out = 1'b0;
            break;
         end
         if (bus.O_data_lane0_idelay != prev) points++;
         prev = bus.O_data_lane0_idelay;
         t    = int'(bus.O_data_lane0_idelay);
         for (int l = 0; l < 4; l++) e[l] = ~lane_pass(mode, l, t);
         bus.I_lane_error = e;
         bus.I_start      = (poke && cyc == 100);
         @(negedge clk);
      end
      bus.I_start      = 1'b0;
      bus.I_lane_error = '0;
      check($sformatf("m%0d_timeout", mode), 32'(timed_out), 32'd0);
      check($sformatf("m%0d_done", mode), 32'(bus.O_done), 32'd1);
   endtask

   task automatic check_taps(input string tag, input int t0, input int t1, input int t2,
                             input int t3, input logic [3:0] fail);
      check({tag, "_tap0"}, 32'(bus.O_data_lane0_idelay), 32'(t0));
      check({tag, "_tap1"}, 32'(bus.O_data_lane1_idelay), 32'(t1));
      check({tag, "_tap2"}, 32'(bus.O_data_lane2_idelay), 32'(t2));
      check({tag, "_tap3"}, 32'(bus.O_data_lane3_idelay), 32'(t3));
      check({tag, "_fail"}, 32'(bus.O_lane_fail), 32'(fail));
   endtask

   initial begin
      int pts;
      checks           = 0;
      failures         = 0;
      rst_n            = 1'b0;
      bus.I_start      = 1'b0;
      bus.I_hs_valid   = 1'b0;
      bus.I_lane_error = '0;
      repeat (3) @(negedge clk);

      // Reset state.
      check_taps("reset", 128, 128, 128, 128, 4'h0);
      check("reset_busy", 32'(bus.O_busy), 32'd0);
      check("reset_done", 32'(bus.O_done), 32'd0);
      check("clk_tap", 32'(bus.O_clk_lane_idelay), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset in the middle of a sweep.
      bus.I_hs_valid = 1'b1;
      bus.I_start    = 1'b1;
      @(negedge clk);
      bus.I_start = 1'b0;
      repeat (50) @(negedge clk);
      check("midrun_busy", 32'(bus.O_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_taps("async_rst", 128, 128, 128, 128, 4'h0);
      check("async_rst_busy", 32'(bus.O_busy), 32'd0);
      check("async_rst_done", 32'(bus.O_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single eye on lane 0; lane 1 clean everywhere; start poked while busy.
      run_sweep(0, 1'b1, pts);
      check("m0_points", 32'(pts), 32'd64);
      check_taps("m0", 128, 252, 128, 128, 4'b1100);
      repeat (10) @(negedge clk);
      check("m0_hold_tap0", 32'(bus.O_data_lane0_idelay), 32'd128);
      check("m0_hold_busy", 32'(bus.O_busy), 32'd0);

      // Equal windows, two windows, open edge run, always erroring lane.
      run_sweep(1, 1'b0, pts);
      check_taps("m1", 12, 260, 452, 128, 4'b1000);

      // Window length just below and exactly at the minimum.
      run_sweep(2, 1'b0, pts);
      check_taps("m2", 128, 12, 252, 252, 4'b0001);

      // No HS traffic at all.
      run_sweep(3, 1'b0, pts);
      check_taps("m3", 128, 128, 128, 128, 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
